// File: rtl/aes_block_uart_tx.sv
// aes_block_uart_tx
// Serialises one NUM_BYTES*8-bit AES result block onto a UART TX line as
// NUM_BYTES back-to-back 8N1 frames, most significant byte first, each byte
// sent LSB first. Every output, including the serial line, comes straight
// from a flop so the pin never glitches.
module aes_block_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BYTES*8-1:0] data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int BLOCK_W = NUM_BYTES * 8;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    baud_cnt;
    logic [2:0]          bit_idx;
    logic [BYTE_W-1:0]   byte_idx;
    logic [BLOCK_W-1:0]  shreg;
    logic [7:0]          cur_byte;
    logic                baud_end;
    logic                accept;
    logic                next_byte;

    // The byte on the wire is always the top byte of the shift register.
    assign cur_byte  = shreg[BLOCK_W-1 -: 8];
    assign baud_end  = (baud_cnt == CNT_LAST);
    assign accept    = (state == IDLE) && data_valid && data_ready;
    assign next_byte = (state == STOP) && baud_end && (byte_idx != BYTE_LAST);

    // Block shift register: loaded on acceptance, advanced one byte at each
    // inter-frame boundary. Pure data, so it carries no reset; its contents
    // are only ever looked at after a fresh load.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= data_in;
        end else if (next_byte) begin
            shreg <= shreg << 8;
        end
    end

    // Framing FSM: sequences start/data/stop bits and drives all outputs
    // as registers. The next tx level is decided on the edge that enters
    // each bit, so tx changes exactly on bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx         <= 1'b1;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid && data_ready) begin
                        state      <= START;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        byte_idx   <= '0;
                        tx         <= 1'b0;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx != BYTE_LAST) begin
                            // No gap: the next start bit follows immediately.
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// tb_aes_block_uart_tx
// Drives a fast instance (8 clocks/bit, 16 bytes) and a default-rate instance
// (868 clocks/bit, 2 bytes). Stimulus pushes expected bytes into per-instance
// queues; independent UART decoders pop and compare every received frame.
module tb_aes_block_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [127:0] data_f;
    logic         valid_f;
    logic         ready_f, tx_f, busy_f, done_f;
    logic [15:0]  data_s;
    logic         valid_s;
    logic         ready_s, tx_s, busy_s, done_s;

    aes_block_uart_tx #(.CLKS_PER_BIT(8), .NUM_BYTES(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_f), .data_valid(valid_f),
        .data_ready(ready_f), .tx(tx_f), .busy(busy_f), .done(done_f)
    );

    aes_block_uart_tx #(.CLKS_PER_BIT(868), .NUM_BYTES(2)) dut_slow (
        .clk(clk), .reset(reset), .data_in(data_s), .data_valid(valid_s),
        .data_ready(ready_s), .tx(tx_s), .busy(busy_s), .done(done_s)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_f[$];
    logic [7:0] exp_s[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    // Decode one frame whose first start-bit sample is the current one.
    // Every sample inside a bit must match the first, so any bit that is
    // not exactly cpb cycles wide breaks the shape.
    task automatic mon_frame(input bit slow, output bit aborted, output bit shape_ok,
                             output logic [7:0] b);
        int   cpb;
        logic v, v0;
        cpb = slow ? 868 : 8;
        aborted = 1'b0; shape_ok = 1'b1; b = '0; v0 = 1'b0;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < cpb; k++) begin
                if (p != 0 || k != 0) @(negedge clk);
                if (reset !== 1'b1) begin
                    aborted = 1'b1;
                    return;
                end
                v = slow ? tx_s : tx_f;
                if (k == 0) v0 = v;
                else if (v !== v0) shape_ok = 1'b0;
            end
            if (p == 0) begin
                if (v0 !== 1'b0) shape_ok = 1'b0;
            end else if (p == 9) begin
                if (v0 !== 1'b1) shape_ok = 1'b0;
            end else begin
                b[p-1] = v0;
            end
        end
    endtask

    task automatic monitor(input bit slow);
        bit aborted, ok;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (slow ? tx_s : tx_f) === 1'b0) begin
                mon_frame(slow, aborted, ok, b);
                if (!aborted) begin
                    chk(slow ? "slow_frame_shape" : "fast_frame_shape", 32'(ok), 32'd1);
                    if (slow ? (exp_s.size() == 0) : (exp_f.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL %s unexpected byte got %0h want none",
                                 slow ? "slow_byte" : "fast_byte", b);
                    end else if (slow) begin
                        chk("slow_byte", 32'(b), 32'(exp_s.pop_front()));
                    end else begin
                        chk("fast_byte", 32'(b), 32'(exp_f.pop_front()));
                    end
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    // Wait (bounded) for done; latency counts cycles from the sample before
    // the accept edge, so the start bit is at 1 and done at 1+frames*80.
    task automatic wait_done(input bit slow, input int c0, input int lat, input string nm);
        int g;
        g = 0;
        while (((slow ? done_s : done_f) !== 1'b1) && g < lat + 20) begin
            @(negedge clk);
            g++;
        end
        if ((slow ? done_s : done_f) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got no done want done", nm);
        end else begin
            chk(nm, 32'(cyc - c0), 32'(lat));
        end
    endtask

    task automatic check_idle_after_done(input string nm);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 32'(done_f), 32'd0);
        chk({nm, "_busy_low"}, 32'(busy_f), 32'd0);
        chk({nm, "_ready_high"}, 32'(ready_f), 32'd1);
        chk({nm, "_all_bytes_seen"}, 32'(exp_f.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [7:0]   ea[16];
        logic [7:0]   eb[16];
        logic [127:0] blk;
        int c0, cd, dev, dn;

        reset = 1'b0; valid_f = 1'b0; data_f = '0; valid_s = 1'b0; data_s = '0;
        repeat (3) @(negedge clk);

        // Test 1: reset values and quiet idle
        chk("rst_tx", 32'(tx_f), 32'd1);
        chk("rst_ready", 32'(ready_f), 32'd1);
        chk("rst_busy", 32'(busy_f), 32'd0);
        chk("rst_done", 32'(done_f), 32'd0);
        chk("rst_slow_tx", 32'(tx_s), 32'd1);
        reset = 1'b1;
        dev = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_f !== 1'b1 || ready_f !== 1'b1 || busy_f !== 1'b0 || done_f !== 1'b0) dev++;
        end
        chk("idle_hold", 32'(dev), 32'd0);

        // Test 2: counting block, bytes 00,11,...,FF
        for (int i = 0; i < 16; i++) exp_f.push_back(8'(i * 8'h11));
        c0 = cyc;
        data_f = 128'h00112233445566778899AABBCCDDEEFF;
        valid_f = 1'b1;
        @(negedge clk);
        valid_f = 1'b0;
        chk("t2_start_bit", 32'(tx_f), 32'd0);
        chk("t2_busy", 32'(busy_f), 32'd1);
        chk("t2_ready_low", 32'(ready_f), 32'd0);
        wait_done(1'b0, c0, 1 + 16 * 80, "t2_done_latency");
        check_idle_after_done("t2");

        // Test 3: all 0x55, with input noise while busy
        repeat (16) exp_f.push_back(8'h55);
        @(negedge clk);
        c0 = cyc;
        data_f = {16{8'h55}};
        valid_f = 1'b1;
        @(negedge clk);
        valid_f = 1'b0;
        repeat (300) @(negedge clk);
        dev = 0;
        for (int i = 0; i < 8; i++) begin
            valid_f = ~valid_f;
            data_f = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            if (ready_f !== 1'b0 || busy_f !== 1'b1) dev++;
        end
        valid_f = 1'b0;
        chk("t3_ready_stays_low", 32'(dev), 32'd0);
        wait_done(1'b0, c0, 1 + 16 * 80, "t3_done_latency");
        check_idle_after_done("t3");

        // Test 4: reset in bit 3 of byte 5 (byte 5 = F0, bit 3 = 0)
        ea = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) exp_f.push_back(ea[i]);
        c0 = cyc;
        data_f = 128'h0123456789F0CDEFFEDCBA9876543210;
        valid_f = 1'b1;
        @(negedge clk);
        valid_f = 1'b0;
        while (cyc - c0 < 5 * 80 + 36) @(negedge clk);
        chk("t4_pre_reset_bit3", 32'(tx_f), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("t4_rst_tx", 32'(tx_f), 32'd1);
        chk("t4_rst_busy", 32'(busy_f), 32'd0);
        chk("t4_rst_ready", 32'(ready_f), 32'd1);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_f !== 1'b0) dn++;
        end
        chk("t4_no_done", 32'(dn), 32'd0);
        chk("t4_bytes_before_reset", 32'(exp_f.size()), 32'd0);
        // Release reset with data_valid already high
        repeat (16) exp_f.push_back(8'hFF);
        c0 = cyc;
        data_f = {16{8'hFF}};
        valid_f = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        valid_f = 1'b0;
        chk("t4_accept_after_release", 32'(tx_f), 32'd0);
        wait_done(1'b0, c0, 1 + 16 * 80, "t4_done_latency");
        check_idle_after_done("t4");

        // Test 5: data_valid held high across two blocks
        ea = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
               8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
        eb = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE,
               8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        for (int i = 0; i < 16; i++) exp_f.push_back(ea[i]);
        c0 = cyc;
        data_f = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        valid_f = 1'b1;
        @(negedge clk);
        chk("t5_start_a", 32'(tx_f), 32'd0);
        repeat (10) @(negedge clk);
        blk = 128'h1032547698BADCFE0123456789ABCDEF;
        data_f = blk;
        for (int i = 0; i < 16; i++) exp_f.push_back(eb[i]);
        wait_done(1'b0, c0, 1 + 16 * 80, "t5_done_a");
        chk("t5_ready_with_done", 32'(ready_f), 32'd1);
        chk("t5_idle_gap_tx", 32'(tx_f), 32'd1);
        cd = cyc;
        @(negedge clk);
        valid_f = 1'b0;
        chk("t5_start_b", 32'(tx_f), 32'd0);
        chk("t5_busy_b", 32'(busy_f), 32'd1);
        wait_done(1'b0, cd, 1 + 16 * 80, "t5_done_b");
        check_idle_after_done("t5");

        // Test 6: default 868 clocks per bit, two bytes of A5
        repeat (2) exp_s.push_back(8'hA5);
        c0 = cyc;
        data_s = 16'hA5A5;
        valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
        chk("t6_start_bit", 32'(tx_s), 32'd0);
        wait_done(1'b1, c0, 1 + 2 * 10 * 868, "t6_done_latency");
        @(negedge clk);
        chk("t6_busy_low", 32'(busy_s), 32'd0);
        chk("t6_all_bytes_seen", 32'(exp_s.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
